ex_muldiv: RTL and testbench

Iterative multiply/divide unit inside the EX stage. It consumes rs/rt operands and the mult/multu/div/divu decode carried on the ID-to-EX bus, and produces a 64-bit {hi,lo} result. While it works it raises a stall request that freezes IF/ID/EX. Its hi/lo write-enable result feeds the MEM/WB hilo path that the ID stage forwards from.

---
 rtl/ex_muldiv.sv | 214 +++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : Iterative 32-bit multiply/divide unit for the EX stage.
//               Shift-add multiply (LSB first) and restoring divide (MSB
//               first), one bit per cycle, with sign fix-up on completion.
//               Raises a stall request while busy and pulses done/whilo_e
//               for one cycle with registered {hi,lo} results.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [DW-1:0] src_a,
   input  logic [DW-1:0] src_b,
   input  logic          cancel,
   output logic          stallreq,
   output logic          done,
   output logic [DW-1:0] hi_out,
   output logic [DW-1:0] lo_out,
   output logic          whilo_e
);

   localparam int CW = $clog2(DW);
   localparam logic [CW-1:0] c_cnt_last = CW'(DW - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            is_div_q, is_div_d;
   logic            sa_q, sa_d;
   logic            sb_q, sb_d;
   logic [DW-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
   logic [2*DW-1:0] acc_q, acc_d;     // product / {remainder, quotient}
   logic [DW-1:0]   hi_q, hi_d;
   logic [DW-1:0]   lo_q, lo_d;
   logic            done_q, done_d;

   // Operand magnitudes at issue; unsigned ops keep raw values
   logic            w_signed_op;
   logic            w_sa;
   logic            w_sb;
   logic [DW-1:0]   w_mag_a;
   logic [DW-1:0]   w_mag_b;

   // One iteration of either algorithm
   logic [DW:0]     w_mul_sum;
   logic [2*DW-1:0] w_mul_next;
   logic [DW:0]     w_partial;
   logic            w_q_bit;
   logic [DW-1:0]   w_rem_new;
   logic [2*DW-1:0] w_div_next;
   logic [2*DW-1:0] w_step_next;

   // Sign-corrected final results
   logic [2*DW-1:0] w_prod_fix;
   logic [DW-1:0]   w_quot_fix;
   logic [DW-1:0]   w_rem_fix;

   // Issue-time operand conditioning
   always_comb begin
      w_signed_op = ~op[0];
      w_sa        = w_signed_op & src_a[DW-1];
      w_sb        = w_signed_op & src_b[DW-1];
      w_mag_a     = w_sa ? (~src_a + 1'b1) : src_a;
      w_mag_b     = w_sb ? (~src_b + 1'b1) : src_b;
   end

   // Single iteration datapath plus sign fix-up of the iteration result
   always_comb begin
      // Multiply: add multiplicand into the upper half when the current
      // multiplier bit (acc[0]) is set, then shift the whole thing right.
      w_mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      w_mul_next  = {w_mul_sum, acc_q[DW-1:1]};

      // Divide: shift left one bit; the 33-bit partial remainder covers the
      // bit shifted out of the top. The subtraction only matters when it
      // cannot borrow, so a 32-bit difference is exact in that case.
      w_partial   = acc_q[2*DW-1:DW-1];
      w_q_bit     = (w_partial >= {1'b0, opb_q});
      w_rem_new   = w_q_bit ? (w_partial[DW-1:0] - opb_q) : w_partial[DW-1:0];
      w_div_next  = {w_rem_new, acc_q[DW-2:0], w_q_bit};

      w_step_next = is_div_q ? w_div_next : w_mul_next;

      // Quotient follows sa^sb; remainder follows the dividend's sign
      w_prod_fix  = (sa_q ^ sb_q) ? (~w_step_next + 1'b1) : w_step_next;
      w_quot_fix  = (sa_q ^ sb_q) ? (~w_step_next[DW-1:0] + 1'b1)
                                  : w_step_next[DW-1:0];
      w_rem_fix   = sa_q ? (~w_step_next[2*DW-1:DW] + 1'b1)
                         : w_step_next[2*DW-1:DW];
   end

   // Next-state and next-output logic; cancel overrides everything
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               is_div_d = op[1];
               sa_d     = w_sa;
               sb_d     = w_sb;
               cnt_d    = '0;
               if (op[1] && (src_b == '0)) begin
                  // Divide by zero: fixed result, no iteration
                  hi_d    = src_a;
                  lo_d    = '1;
                  done_d  = 1'b1;
                  state_d = S_FIN;
               end else if (op[1]) begin
                  acc_d   = {{DW{1'b0}}, w_mag_a};
                  opb_d   = w_mag_b;
                  state_d = S_RUN;
               end else begin
                  acc_d   = {{DW{1'b0}}, w_mag_b};
                  opb_d   = w_mag_a;
                  state_d = S_RUN;
               end
            end
         end

         S_RUN: begin
            acc_d = w_step_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == c_cnt_last) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = S_FIN;
               if (is_div_q) begin
                  hi_d = w_rem_fix;
                  lo_d = w_quot_fix;
               end else begin
                  hi_d = w_prod_fix[2*DW-1:DW];
                  lo_d = w_prod_fix[DW-1:0];
               end
            end
         end

         S_FIN: begin
            // Held instruction is ignored here so it does not restart
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (cancel) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         done_d  = 1'b0;
         hi_d    = '0;
         lo_d    = '0;
      end
   end

   // State and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         opb_q    <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   // Stall is combinational so the pipeline freezes in the issue cycle
   always_comb begin
      stallreq = (((state_q == S_IDLE) && start) || (state_q == S_RUN)) && !cancel;
      done     = done_q;
      whilo_e  = done_q;
      hi_out   = hi_q;
      lo_out   = lo_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Self-checking bench for ex_muldiv: directed cases plus
//               random operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        cancel = 1'b0;
   logic        stallreq;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        whilo_e;

   int errors = 0;
   int checks = 0;
   int gcyc = 0;
   int last_done_cyc = 0;

   ex_muldiv #(.DW(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .src_a    (src_a),
      .src_b    (src_b),
      .cancel   (cancel),
      .stallreq (stallreq),
      .done     (done),
      .hi_out   (hi_out),
      .lo_out   (lo_out),
      .whilo_e  (whilo_e)
   );

   always #5 clk = ~clk;
   always @(posedge clk) gcyc <= gcyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic on the architectural definitions
   function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = '0;
      case (o)
         2'b00: r = 64'(sa * sb);
         2'b01: r = ua * ub;
         2'b10: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else begin
               sq = sa / sb;
               sr = sa % sb;
               r  = {sr[31:0], sq[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else begin
               uq = ua / ub;
               ur = ua % ub;
               r  = {ur[31:0], uq[31:0]};
            end
         end
      endcase
      return r;
   endfunction

   // Issue an op (called just after a rising edge); returns at the falling
   // edge of the done cycle with start still held.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat);
      logic [63:0] exp;
      int          cyc;
      bit          got;
      exp   = ref_model(o, a, b);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      cyc   = 0;
      got   = 1'b0;
      while (cyc <= 40 && !got) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            last_done_cyc = gcyc;
         end else begin
            chk({tag, " stallreq busy"}, {63'd0, stallreq}, 64'd1);
            @(posedge clk); #1;
            cyc++;
            if (cyc == 5) begin
               src_a = ~src_a;
               src_b = src_b ^ 32'h0000_0005;
            end
         end
      end
      chk({tag, " done seen"}, {63'd0, got}, 64'd1);
      chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
      chk({tag, " stallreq fin"}, {63'd0, stallreq}, 64'd0);
      chk({tag, " whilo_e"}, {63'd0, whilo_e}, 64'd1);
      chk({tag, " hi"}, {32'd0, hi_out}, {32'd0, exp[63:32]});
      chk({tag, " lo"}, {32'd0, lo_out}, {32'd0, exp[31:0]});
   endtask

   // Release start after done and confirm done was a single-cycle pulse
   task automatic go_idle(input string tag);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk({tag, " done pulse width"}, {63'd0, done}, 64'd0);
      @(posedge clk); #1;
   endtask

   // Watch a window in which no completion may occur
   task automatic quiet_window(input string tag);
      bit saw;
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || whilo_e) saw = 1'b1;
      end
      chk({tag, " no done"}, {63'd0, saw}, 64'd0);
      chk({tag, " hi cleared"}, {32'd0, hi_out}, 64'd0);
      chk({tag, " lo cleared"}, {32'd0, lo_out}, 64'd0);
      chk({tag, " stallreq idle"}, {63'd0, stallreq}, 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int first_done;
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset whilo_e", {63'd0, whilo_e}, 64'd0);
      chk("reset stallreq", {63'd0, stallreq}, 64'd0);
      chk("reset hi", {32'd0, hi_out}, 64'd0);
      chk("reset lo", {32'd0, lo_out}, 64'd0);
      @(posedge clk); #1;

      run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      go_idle("multu max");
      chk("hold hi", {32'd0, hi_out}, 64'h0000_0000_FFFF_FFFE);
      chk("hold lo", {32'd0, lo_out}, 64'h0000_0000_0000_0001);

      run_op("mult -3x5", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 33);
      go_idle("mult -3x5");

      run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 33);
      first_done = last_done_cyc;
      @(posedge clk); #1;
      run_op("divu 100/7 b2b", 2'b11, 32'd100, 32'd7, 33);
      chk("b2b spacing", 64'(last_done_cyc - first_done), 64'd34);
      go_idle("divu 100/7");

      run_op("div by zero", 2'b10, 32'h1234_5678, 32'h0000_0000, 1);
      go_idle("div by zero");

      run_op("div overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33);
      go_idle("div overflow");

      // Cancel at cycle 10 of a divu
      start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd3;
      repeat (10) begin @(posedge clk); #1; end
      cancel = 1'b1;
      #1 chk("cancel stallreq", {63'd0, stallreq}, 64'd0);
      @(posedge clk); #1;
      cancel = 1'b0;
      start  = 1'b0;
      quiet_window("cancel");
      run_op("multu 6x7", 2'b01, 32'd6, 32'd7, 33);
      go_idle("multu 6x7");

      // Reset at cycle 20 of a mult
      start = 1'b1; op = 2'b00; src_a = 32'h0001_2345; src_b = 32'hFFFF_0001;
      repeat (20) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      quiet_window("rst mid run");

      // Random operations
      for (int i = 0; i < 20; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom;
         r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 300));
         run_op("random", r_op, r_a, r_b, (r_op[1] && r_b == 32'd0) ? 1 : 33);
         go_idle("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
